// File: rtl/input_cond_pkg.sv
// ---------------------------------------------------------------------------
// input_cond_pkg
//   Shared definitions for the two-channel switch input conditioner.
//   - State encoding of the per-channel debounce FSM (ZERO/WAIT1/ONE/WAIT0)
//   - Counter width helper used to size the debounce counter
// ---------------------------------------------------------------------------
package input_cond_pkg;

    // Debounce FSM state encoding.
    localparam logic [1:0] ZERO  = 2'b00;
    localparam logic [1:0] WAIT1 = 2'b01;
    localparam logic [1:0] ONE   = 2'b10;
    localparam logic [1:0] WAIT0 = 2'b11;

    typedef enum logic [1:0] {
        ST_ZERO  = ZERO,
        ST_WAIT1 = WAIT1,
        ST_ONE   = ONE,
        ST_WAIT0 = WAIT0
    } db_state_e;

    // Width of a counter that must reach cycles-1. Never narrower than
    // one bit so illegal/degenerate values still elaborate far enough to
    // hit the explicit DB_CYCLES check.
    function automatic int cnt_width(input int cycles);
        if (cycles <= 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/input_cond_2ch_db_channel.sv
// ---------------------------------------------------------------------------
// db_channel
//   One debounced input channel: 2-flop synchronizer, 4-state debounce FSM
//   with a saturating up-counter, registered level output and a one-cycle
//   rising-edge tick.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   ZERO  | accepted level is 0, synchronized input agrees
//   WAIT1 | level 0, input seen high, counting stable-high cycles
//   ONE   | accepted level is 1, synchronized input agrees
//   WAIT0 | level 1, input seen low, counting stable-low cycles
//
// Ports
//   clk_i    : clock, all logic on rising edge
//   reset_i  : synchronous active-high reset
//   raw_i    : raw asynchronous switch input
//   level_o  : debounced level (registered, 1 in ONE or WAIT0)
//   tick_o   : one-cycle pulse on the cycle level first becomes 1
// ---------------------------------------------------------------------------
module db_channel
    import input_cond_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic level_o,
    output logic tick_o
);

    localparam int               CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DB_CYCLES < 2) begin : g_db_cycles_check
        $error("db_channel: DB_CYCLES must be at least 2");
    end

    logic             sync1_q;
    logic             sync2_q;
    db_state_e        state_q;
    db_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             tick_q;
    logic             tick_d;

    // State / counter / output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic. The compare against CNT_LAST is the only way out
    // of a WAIT state other than the input reverting, so cnt cannot wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ZERO: begin
                if (sync2_q) begin
                    state_d = ST_WAIT1;
                    cnt_d   = '0;
                end
            end
            ST_WAIT1: begin
                if (!sync2_q) begin
                    state_d = ST_ZERO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ONE: begin
                if (!sync2_q) begin
                    state_d = ST_WAIT0;
                    cnt_d   = '0;
                end
            end
            ST_WAIT0: begin
                if (sync2_q) begin
                    state_d = ST_ONE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_ZERO;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode, computed from the next state so the registered
    // outputs line up with the state register (glitch-free level).
    // The tick fires only on WAIT1->ONE, never on WAIT0->ONE.
    always_comb begin
        level_d = (state_d == ST_ONE) || (state_d == ST_WAIT0);
        tick_d  = (state_q == ST_WAIT1) && (state_d == ST_ONE);
    end

    assign level_o = level_q;
    assign tick_o  = tick_q;

endmodule

// File: rtl/input_cond_2ch.sv
// ---------------------------------------------------------------------------
// input_cond_2ch
//   Two independent debounced switch inputs feeding a downstream FSM.
//   Each channel is a db_channel instance; both share clock, reset and the
//   debounce length, so simultaneous clean edges produce simultaneous
//   outputs.
//
// Ports
//   clk     : clock
//   reset   : synchronous active-high reset
//   sw_a    : raw bouncing switch A
//   sw_b    : raw bouncing switch B
//   a       : debounced level of sw_a
//   b       : debounced level of sw_b
//   a_tick  : one-cycle pulse when a goes 0->1
//   b_tick  : one-cycle pulse when b goes 0->1
// ---------------------------------------------------------------------------
module input_cond_2ch
    import input_cond_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_a,
    input  logic sw_b,
    output logic a,
    output logic b,
    output logic a_tick,
    output logic b_tick
);

    db_channel #(
        .DB_CYCLES (DB_CYCLES)
    ) u_ch_a (
        .clk_i   (clk),
        .reset_i (reset),
        .raw_i   (sw_a),
        .level_o (a),
        .tick_o  (a_tick)
    );

    db_channel #(
        .DB_CYCLES (DB_CYCLES)
    ) u_ch_b (
        .clk_i   (clk),
        .reset_i (reset),
        .raw_i   (sw_b),
        .level_o (b),
        .tick_o  (b_tick)
    );

endmodule

// File: doc/input_cond_2ch.md
INPUT_COND_2CH -- requirements
Module: input_cond_2ch

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, is the number of consecutive clk cycles a synchronized input must hold a new level before it is accepted (10 ms at 100 MHz).
REQ-002 clk  input  1  single rising-edge clock for all logic.
REQ-003 reset  input  1  synchronous, active-high reset; it is sampled only on the rising edge of clk.
REQ-004 sw_a  input  1  raw, asynchronous, bouncing switch A.
REQ-005 sw_b  input  1  raw, asynchronous, bouncing switch B.
REQ-006 a  output  1  debounced level of sw_a; it drives the downstream FSM input a.
REQ-007 b  output  1  debounced level of sw_b; it drives the downstream FSM input b.
REQ-008 a_tick  output  1  one-cycle pulse when a goes 0->1.
REQ-009 b_tick  output  1  one-cycle pulse when b goes 0->1.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer; the second flop is the synchronized level s.
REQ-011 Each channel SHALL run an independent 4-state FSM (ZERO, WAIT1, ONE, WAIT0) with a counter cnt.
- cnt width: clog2(DB_CYCLES).
REQ-012 ZERO: when s=1, go to WAIT1 and set cnt=0; otherwise stay in ZERO.
REQ-013 WAIT1: when s=0, go to ZERO and discard the count.
- When s=1 and cnt==DB_CYCLES-1, go to ONE.
- Otherwise increment cnt.
REQ-014 ONE: when s=0, go to WAIT0 and set cnt=0; otherwise stay in ONE.
REQ-015 WAIT0: when s=1, go to ONE.
- When s=0 and cnt==DB_CYCLES-1, go to ZERO.
- Otherwise increment cnt.
REQ-016 The level output (a or b) SHALL be 1 exactly when the channel state is ONE or WAIT0.
- The level output is a registered state decode and SHALL never glitch.
REQ-017 The tick output SHALL be registered and high for exactly the one cycle in which the state first equals ONE after WAIT1.
- Consecutive ticks are separated by at least 2*DB_CYCLES+2 cycles.
REQ-018 Latency for a clean edge: if the raw input is first sampled high at clk edge k and stays high, the level output SHALL be 1 after edge k+DB_CYCLES+2.
- The tick SHALL be high in that same cycle.
- The falling edge is symmetric, with no tick.
REQ-019 Any bounce shorter than DB_CYCLES consecutive stable cycles SHALL leave the level output unchanged and produce no tick.
REQ-020 The two channels SHALL be fully independent.
- Simultaneous edges on sw_a and sw_b give simultaneous, identical-latency outputs.
- a=b=1 can be presented in the same cycle.
REQ-021 cnt SHALL never wrap.
- The saturating compare at DB_CYCLES-1 is the only exit from a WAIT state other than level reversion.
REQ-022 DB_CYCLES < 2 is illegal; the RTL SHALL contain an elaboration-time check that fails on it.

Reset
REQ-023 While reset=1 at a clk edge:
- synchronizer flops, cnt and state SHALL load 0 / ZERO;
- a, b, a_tick and b_tick SHALL be 0 in the following cycle.
REQ-024 Reset mid-WAIT SHALL abandon the pending transition.
- An input held high through reset release SHALL be accepted after the full REQ-018 latency and SHALL produce a tick.
REQ-025 There SHALL be no asynchronous reset path.

Structure
REQ-026 A shared package input_cond_pkg SHALL hold:
- the state encoding localparams ZERO=2'b00, WAIT1=2'b01, ONE=2'b10, WAIT0=2'b11;
- the counter-width function.
REQ-027 One sub-module, db_channel, SHALL implement one channel (synchronizer, FSM, counter, level, tick).
- input_cond_2ch SHALL instantiate db_channel twice.
REQ-028 Each db_channel SHALL split into three parts: a state/counter register block, combinational next-state logic, and output decode.

Verification (DB_CYCLES=4 for simulation)
REQ-029 Reset with sw_a=sw_b=0, then release -> a=b=a_tick=b_tick=0 for 20 cycles.
REQ-030 sw_a 0->1 first sampled at edge 10 and held -> a=1 and a_tick=1 after edge 16 only; a_tick=0 after edge 17.
REQ-031 sw_a toggles 1,0,1,0 every 2 cycles, then stays 0 -> a stays 0, no a_tick.
REQ-032 sw_a and sw_b rise on the same edge and hold -> a, b, a_tick, b_tick all rise in the same cycle; the downstream FSM sees a=b=1.
REQ-033 Assert reset for 1 cycle while channel A is in WAIT1 (cnt=2), with sw_a held high -> a=0 after reset; a rises DB_CYCLES+2 edges after release, with a_tick.
REQ-034 With a=1, sw_a falls and stays low -> a=0 after DB_CYCLES+2 edges, no tick; a 3-cycle low glitch instead leaves a=1.
